// File: rtl/ioconfig_ctrl_pkg.sv
// Shared types for the I/O-block configuration sequencer.
// Optional readback path: IOCFG_READBACK_EN.
package ioblock_cfg_pkg;

  localparam int CFG_BITS_PER_IO = 3;

  typedef logic [1:0] tsmux_t;

  localparam tsmux_t TS_OFF  = 2'b00;
  localparam tsmux_t TS_CTRL = 2'b01;
  localparam tsmux_t TS_DRV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    COMMIT
  } cfg_state_e;

endpackage

// File: rtl/ioconfig_ctrl_if.sv
// Serial config handshake plus live I/O-block control outputs.
// CFG_DOUT exists only with IOCFG_READBACK_EN.
interface ioconfig_ctrl_if #(
  parameter int NUM_IO = 8
);
  logic                  CFG_START;
  logic                  CFG_DIN;
  logic                  CFG_VALID;
  logic                  CFG_READY;
  logic                  CFG_BUSY;
  logic                  CFG_DONE;
  logic                  CFG_ERR;
  logic [2*NUM_IO-1:0]   TSMUX_O;
  logic [NUM_IO-1:0]     DORREG_O;
`ifdef IOCFG_READBACK_EN
  logic                  CFG_DOUT;
`endif

  modport master (
    output CFG_START, CFG_DIN, CFG_VALID,
`ifdef IOCFG_READBACK_EN
    input  CFG_DOUT,
`endif
    input  CFG_READY, CFG_BUSY, CFG_DONE, CFG_ERR,
    input  TSMUX_O, DORREG_O
  );

  modport slave (
    input  CFG_START, CFG_DIN, CFG_VALID,
`ifdef IOCFG_READBACK_EN
    output CFG_DOUT,
`endif
    output CFG_READY, CFG_BUSY, CFG_DONE, CFG_ERR,
    output TSMUX_O, DORREG_O
  );
endinterface

// File: rtl/ioconfig_shreg.sv
// Frame shadow shift register with bit counter and running parity.
// last_o flags that the next accepted bit completes the frame.
module ioconfig_shreg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         shift_en_i,
  input  logic         din_i,
  output logic [W-1:0] data_o,
  output logic         last_o,
  output logic         parity_o
);
  localparam int CW = $clog2(W+1);

  logic [W-1:0]  data_q;
  logic [CW-1:0] cnt_q;
  logic          par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      par_q  <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      par_q  <= 1'b0;
    end else if (shift_en_i) begin
      data_q <= {data_q[W-2:0], din_i};
      cnt_q  <= cnt_q + 1'b1;
      par_q  <= par_q ^ din_i;
    end
  end

  assign data_o   = data_q;
  assign last_o   = (cnt_q == CW'(W-1));
  assign parity_o = par_q;
endmodule

// File: rtl/ioconfig_ctrl.sv
// Config sequencer: serial frame in, even parity check, atomic commit.
// IOCFG_READBACK_EN adds CFG_DOUT streaming out the old config.
module ioconfig_ctrl
  import ioblock_cfg_pkg::*;
#(
  parameter int NUM_IO = 8
) (
  input  logic IOCLK,
  input  logic RST_N,
  ioconfig_ctrl_if.slave cfg
);
  localparam int FB = CFG_BITS_PER_IO * NUM_IO;

  cfg_state_e          state_q, state_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [2*NUM_IO-1:0] ts_q, ts_new;
  logic [NUM_IO-1:0]   dor_q, dor_new;
  logic [FB-1:0]       shadow;
  logic                last, par;
  logic                accept, clr, shift_en, commit, rb_load;

  assign cfg.CFG_READY = (state_q == SHIFT) || (state_q == CHECK);
  assign cfg.CFG_BUSY  = (state_q != IDLE);
  assign accept        = cfg.CFG_VALID && cfg.CFG_READY;

  ioconfig_shreg #(.W(FB)) u_shreg (
    .clk        (IOCLK),
    .rst_n      (RST_N),
    .clr_i      (clr),
    .shift_en_i (shift_en),
    .din_i      (cfg.CFG_DIN),
    .data_o     (shadow),
    .last_o     (last),
    .parity_o   (par)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    done_d   = 1'b0;
    clr      = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    rb_load  = 1'b0;
    unique case (state_q)
      IDLE: if (cfg.CFG_START) begin
        state_d = SHIFT;
        err_d   = 1'b0;
        clr     = 1'b1;
        rb_load = 1'b1;
      end
      SHIFT: if (accept) begin
        shift_en = 1'b1;
        if (last) state_d = CHECK;
      end
      CHECK: if (accept) begin
        if (par ^ cfg.CFG_DIN) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        commit  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ts_new  = '0;
    dor_new = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      ts_new[2*i +: 2] = shadow[3*i+1 +: 2];
      dor_new[i]       = shadow[3*i];
    end
  end

  always_ff @(posedge IOCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ts_q    <= {NUM_IO{TS_OFF}};
      dor_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (commit) begin
        ts_q  <= ts_new;
        dor_q <= dor_new;
      end
    end
  end

  assign cfg.CFG_DONE = done_q;
  assign cfg.CFG_ERR  = err_q;
  assign cfg.TSMUX_O  = ts_q;
  assign cfg.DORREG_O = dor_q;

`ifdef IOCFG_READBACK_EN
  logic [FB-1:0] rb_q, rb_pack;

  always_comb begin
    rb_pack = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      rb_pack[3*i+1 +: 2] = ts_q[2*i +: 2];
      rb_pack[3*i]        = dor_q[i];
    end
  end

  always_ff @(posedge IOCLK or negedge RST_N) begin
    if (!RST_N)        rb_q <= '0;
    else if (rb_load)  rb_q <= rb_pack;
    else if (shift_en) rb_q <= {rb_q[FB-2:0], 1'b0};
  end

  assign cfg.CFG_DOUT = (state_q == SHIFT) ? rb_q[FB-1] : 1'b0;
`else
  logic unused_rb;
  assign unused_rb = rb_load;
`endif
endmodule
